div_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the RV32M divide/remainder datapath in the EX stage. It accepts one DIV/DIVU/REM/REMU operation at a time from the EX stage and runs a radix-2 restoring shift-subtract iteration. It applies RISC-V sign and special-case rules and returns a one-cycle `done_o` pulse with the result and destination register. While it is busy it holds the pipeline stalled.

---
 rtl/div_seq_ctrl.sv | 96 +++++++++
 tb/tb_div_seq_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: radix-2 restoring DIV/DIVU/REM/REMU sequencer; `DIV_EARLY_OUT_EN skips CALC when |rs1| < |rs2|
module div_seq_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t            state;
  logic [XLEN:0]     rem;
  logic [XLEN-1:0]   quo, dvs, a_mag, b_mag, q_fix, r_fix;
  logic [CNT_W-1:0]  cnt;
  logic              neg_q, neg_r, sel_rem, sgn, div_zero, ovf, early, accept;
  logic [4:0]        rd_q;
  logic [XLEN:0]     rem_sh, trial;
  assign sgn      = ~op_i[0];
  assign a_mag    = (sgn & rs1_i[XLEN-1]) ? -rs1_i : rs1_i;
  assign b_mag    = (sgn & rs2_i[XLEN-1]) ? -rs2_i : rs2_i;
  assign div_zero = rs2_i == '0;
  assign ovf      = sgn & (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2_i);
`ifdef DIV_EARLY_OUT_EN
  assign early    = ~div_zero & (a_mag < b_mag);
`else
  assign early    = 1'b0;
`endif
  assign accept   = (state == IDLE) & start_i & ~flush_i;
  assign busy_o   = state != IDLE;
  assign done_o   = state == DONE;
  assign stall_o  = accept | (busy_o & ~done_o);
  assign rem_sh   = {rem[XLEN-1:0], quo[XLEN-1]};
  assign trial    = rem_sh - {1'b0, dvs};
  assign q_fix    = neg_q ? -quo : quo;
  assign r_fix    = (neg_r & (|rem)) ? -rem[XLEN-1:0] : rem[XLEN-1:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      sel_rem  <= 1'b0;
      rd_q     <= '0;
      rd_o     <= '0;
      result_o <= '0;
    end else if (flush_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          rd_q    <= rd_i;
          sel_rem <= op_i[1];
          neg_q   <= sgn & (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
          neg_r   <= sgn & rs1_i[XLEN-1];
          rem     <= '0;
          quo     <= a_mag;
          dvs     <= b_mag;
          cnt     <= CNT_W'(XLEN-1);
          // special cases and early-out finish here with a registered result
          if (div_zero | ovf | early) begin
            state    <= DONE;
            rd_o     <= rd_i;
            result_o <= op_i[1] ? (ovf ? '0 : rs1_i) : (div_zero ? '1 : (ovf ? rs1_i : '0));
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          rem <= trial[XLEN] ? rem_sh : trial;
          quo <= {quo[XLEN-2:0], ~trial[XLEN]};
          if (cnt == '0) state <= FIX;
          else cnt <= cnt - 1'b1;
        end
        FIX: begin
          result_o <= sel_rem ? r_fix : q_fix;
          rd_o     <= rd_q;
          state    <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: vector table, corner sequences and random ops against an arithmetic reference model
module tb_div_seq_ctrl;
  logic        clk = 0, rst_n = 0, start_i = 0, flush_i = 0;
  logic [1:0]  op_i = 0;
  logic [31:0] rs1_i = 0, rs2_i = 0;
  logic [4:0]  rd_i = 0;
  logic        busy_o, stall_o, done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;
  int errors = 0, checks = 0, done_cnt = 0, exp_done = 0;

  div_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .rd_i(rd_i), .flush_i(flush_i), .busy_o(busy_o), .stall_o(stall_o), .done_o(done_o),
    .result_o(result_o), .rd_o(rd_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (done_o) done_cnt <= done_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : a;
    case (op)
      2'b00: return $signed(a) / $signed(b);
      2'b01: return a / b;
      2'b10: return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  function automatic logic [31:0] mag(input logic sgn, input logic [31:0] v);
    return (sgn && v[31]) ? 32'(0 - v) : v;
  endfunction

  // edges after the accept edge until done_o is visible
  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return 0;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
`ifdef DIV_EARLY_OUT_EN
    if (mag(!op[0], a) < mag(!op[0], b)) return 0;
`endif
    return 33;
  endfunction

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp);
    int k = 0;
    int exp_k = ref_lat(op, a, b);
    @(negedge clk);
    start_i = 1; op_i = op; rs1_i = a; rs2_i = b; rd_i = rd;
    #1 chk("stall_on_req", {31'b0, stall_o}, 1);
    @(posedge clk); #1;
    chk("busy_after_accept", {31'b0, busy_o}, 1);
    rs1_i = $urandom; rs2_i = $urandom; rd_i = 5'($urandom); op_i = 2'($urandom);
    while (!done_o && k < 60) begin
      @(posedge clk); #1; k++;
    end
    exp_done++;
    chk("done_seen", {31'b0, done_o}, 1);
    chk("latency", k, exp_k);
    chk("result", result_o, exp);
    chk("rd", {27'b0, rd_o}, {27'b0, rd});
    chk("stall_in_done", {31'b0, stall_o}, 0);
    start_i = 0;
    @(posedge clk); #1;
    chk("done_single_pulse", {31'b0, done_o}, 0);
    chk("idle_after_done", {31'b0, busy_o}, 0);
    chk("result_held", result_o, exp);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];
  logic [31:0] prev_res, a, b;
  logic [4:0]  prev_rd;
  logic [1:0]  op;

  initial begin
    vecs[0]  = '{2'b00, 32'd84,         32'd12,         5'd5,  32'd7};
    vecs[1]  = '{2'b00, -32'sd84,       32'd12,         5'd6,  32'hFFFF_FFF9};
    vecs[2]  = '{2'b10, -32'sd7,        32'd2,          5'd7,  32'hFFFF_FFFF};
    vecs[3]  = '{2'b01, 32'd100,        32'd4,          5'd8,  32'd25};
    vecs[4]  = '{2'b11, 32'hFFFF_FFFF,  32'd10,         5'd9,  32'd5};
    vecs[5]  = '{2'b01, 32'd5,          32'd0,          5'd10, 32'hFFFF_FFFF};
    vecs[6]  = '{2'b10, 32'd5,          32'd0,          5'd11, 32'd5};
    vecs[7]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'h8000_0000};
    vecs[8]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'd0};
    vecs[9]  = '{2'b00, 32'd3,          32'd7,          5'd14, 32'd0};
    vecs[10] = '{2'b10, -32'sd3,        32'd7,          5'd15, 32'hFFFF_FFFD};
    vecs[11] = '{2'b00, 32'd7,          -32'sd2,        5'd16, 32'hFFFF_FFFD};
    vecs[12] = '{2'b10, 32'd7,          -32'sd2,        5'd31, 32'd1};

    #2;
    chk("rst_busy", {31'b0, busy_o}, 0);
    chk("rst_done", {31'b0, done_o}, 0);
    chk("rst_result", result_o, 0);
    chk("rst_rd", {27'b0, rd_o}, 0);
    chk("rst_stall", {31'b0, stall_o}, 0);
    @(negedge clk); rst_n = 1;

    for (int i = 0; i < 13; i++) do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp);

    // flush in the middle of CALC
    prev_res = result_o; prev_rd = rd_o;
    @(negedge clk);
    start_i = 1; op_i = 2'b00; rs1_i = 32'd1000; rs2_i = 32'd7; rd_i = 5'd3;
    @(posedge clk); #1 start_i = 0;
    repeat (10) @(posedge clk);
    @(negedge clk) flush_i = 1;
    @(posedge clk); #1;
    chk("flush_busy", {31'b0, busy_o}, 0);
    chk("flush_done", {31'b0, done_o}, 0);
    chk("flush_result", result_o, prev_res);
    chk("flush_rd", {27'b0, rd_o}, {27'b0, prev_rd});
    // flush together with start in IDLE blocks the accept
    start_i = 1;
    #1 chk("flush_start_stall", {31'b0, stall_o}, 0);
    @(posedge clk); #1;
    chk("flush_start_busy", {31'b0, busy_o}, 0);
    flush_i = 0; start_i = 0;
    do_op(2'b00, 32'd9, 32'd1, 5'd9, 32'd9);

    // asynchronous reset mid-CALC
    @(negedge clk);
    start_i = 1; op_i = 2'b01; rs1_i = 32'd77; rs2_i = 32'd5; rd_i = 5'd4;
    @(posedge clk); #1 start_i = 0;
    repeat (5) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_busy", {31'b0, busy_o}, 0);
    chk("arst_done", {31'b0, done_o}, 0);
    chk("arst_result", result_o, 0);
    chk("arst_rd", {27'b0, rd_o}, 0);
    chk("arst_stall", {31'b0, stall_o}, 0);
    @(negedge clk) rst_n = 1;

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 20);
        3: begin b = $urandom; a = $urandom_range(0, 50); end
        default: b = $urandom;
      endcase
      do_op(op, a, b, 5'($urandom), ref_res(op, a, b));
    end

    repeat (3) @(posedge clk); #1;
    chk("done_count", done_cnt, exp_done);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
